// File: rtl/c3lib_skid_buf_vr.sv
// c3lib_skid_buf_vr
//   Two-entry registered skid buffer for a valid/ready stream. Both the
//   forward path (out_vld/out_data) and the reverse path (in_rdy) come
//   straight from flops. There is no combinational path from out_rdy to in_rdy.
//
//   Storage is a main register that drives out_data plus one skid register.
//   The skid register catches the word that arrives in the cycle the
//   downstream stage stalls. The occupancy FSM is EMPTY / ONE / FULL.
//
//   Optional feature macro: C3LIB_SKID_STATS_EN
//     When it is defined, the block adds the CNT_W parameter, the stats_clr
//     input and the stall_cnt output. stall_cnt is a saturating count of the
//     cycles where out_vld & !out_rdy. When it is not defined, the parameter,
//     the ports and the counter are all absent. The datapath is identical in
//     both builds.
//
//   dbg_state exposes the occupancy FSM: 0 = EMPTY, 1 = ONE, 2 = FULL.

module c3lib_skid_buf_vr #(
   parameter int                DWIDTH   = 16,
   parameter logic [DWIDTH-1:0] RST_DATA = '0
`ifdef C3LIB_SKID_STATS_EN
   ,
   parameter int                CNT_W    = 8
`endif
) (
   input  logic              clk,
   input  logic              rst,
   // Handshake: a word moves across an interface on a rising edge where
   // valid and ready are both 1. The producer may drop valid without a
   // transfer. The consumer may toggle ready freely. While valid & !ready,
   // out_data is held stable.
   input  logic              in_vld,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_rdy,
   output logic              out_vld,
   output logic [DWIDTH-1:0] out_data,
   input  logic              out_rdy,
`ifdef C3LIB_SKID_STATS_EN
   input  logic              stats_clr,
   output logic [CNT_W-1:0]  stall_cnt,
`endif
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DWIDTH-1:0] main_q, main_d;
   logic [DWIDTH-1:0] skid_q, skid_d;
   logic              in_rdy_q, in_rdy_d;
   logic              in_xfer;
   logic              out_xfer;

   assign out_vld   = (state_q != EMPTY);
   assign out_data  = main_q;
   assign in_rdy    = in_rdy_q;
   assign dbg_state = state_q;

   // in_rdy_q is 0 whenever state_q is FULL, so in_vld is ignored there.
   assign in_xfer  = in_vld & in_rdy_q;
   assign out_xfer = out_vld & out_rdy;

   // Next occupancy state and register loads for this cycle's transfers.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = in_data;
            end else if (in_xfer) begin
               state_d = FULL;
               skid_d  = in_data;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      // Ready is computed one cycle ahead from the next state so that it can be registered.
      in_rdy_d = (state_d != FULL);
   end

   // State, main word and registered ready. Reset discards any stored words.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= EMPTY;
         main_q   <= RST_DATA;
         in_rdy_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         main_q   <= main_d;
         in_rdy_q <= in_rdy_d;
      end
   end

   // Skid word. Its contents only matter in FULL, so it has no reset.
   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

`ifdef C3LIB_SKID_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;

   assign stall_cnt = stall_cnt_q;

   // Saturating stall counter. A clear takes priority over an increment.
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         stall_cnt_q <= '0;
      end else if (out_vld && !out_rdy && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_c3lib_skid_buf_vr.sv
// tb_c3lib_skid_buf_vr
//   Directed bench for c3lib_skid_buf_vr. It drives inputs 1 time unit after
//   each rising edge. On that same sample point it checks the outputs, which
//   reflect the state after that edge. Define C3LIB_SKID_STATS_EN to build the
//   stall-counter checks with CNT_W = 4.

module tb_c3lib_skid_buf_vr;

   localparam int          DW       = 16;
   localparam logic [15:0] RST_VAL  = 16'hA5C3;
`ifdef C3LIB_SKID_STATS_EN
   localparam int          CW       = 4;
`endif

   logic          clk;
   logic          rst;
   logic          in_vld;
   logic [DW-1:0] in_data;
   logic          in_rdy;
   logic          out_vld;
   logic [DW-1:0] out_data;
   logic          out_rdy;
   logic [1:0]    dbg_state;
`ifdef C3LIB_SKID_STATS_EN
   logic          stats_clr;
   logic [CW-1:0] stall_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [DW-1:0] exp_q[$];

   c3lib_skid_buf_vr #(
      .DWIDTH   (DW),
      .RST_DATA (RST_VAL)
`ifdef C3LIB_SKID_STATS_EN
      ,
      .CNT_W    (CW)
`endif
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (in_vld),
      .in_data   (in_data),
      .in_rdy    (in_rdy),
      .out_vld   (out_vld),
      .out_data  (out_data),
      .out_rdy   (out_rdy),
`ifdef C3LIB_SKID_STATS_EN
      .stats_clr (stats_clr),
      .stall_cnt (stall_cnt),
`endif
      .dbg_state (dbg_state)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to the sample point just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic          prev_stall;
      logic [DW-1:0] prev_data;
      logic          do_in;
      logic          do_out;
      logic [DW-1:0] exp_w;

      rst     = 1'b1;
      in_vld  = 1'b1;
      in_data = 16'hDEAD;
      out_rdy = 1'b1;
`ifdef C3LIB_SKID_STATS_EN
      stats_clr = 1'b0;
`endif

      // 1: reset held for 3 edges, in_vld high
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_out_vld", 32'(out_vld), 32'd0);
         chk("rst_in_rdy", 32'(in_rdy), 32'd0);
         chk("rst_out_data", 32'(out_data), 32'(RST_VAL));
`ifdef C3LIB_SKID_STATS_EN
         chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
      end
      rst    = 1'b0;
      in_vld = 1'b0;
      step();
      chk("rel_in_rdy", 32'(in_rdy), 32'd1);
      chk("rel_out_vld", 32'(out_vld), 32'd0);

      // 2: streaming 0x0001..0x0064 with out_rdy high
      out_rdy = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         in_vld  = 1'b1;
         in_data = 16'(i);
         step();
         chk("strm_in_rdy", 32'(in_rdy), 32'd1);
         chk("strm_out_vld", 32'(out_vld), 32'd1);
         chk("strm_out_data", 32'(out_data), 32'(i));
      end
      in_vld = 1'b0;
      step();
      chk("strm_drained", 32'(out_vld), 32'd0);

      // 3: back-pressure with A, B, C
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      in_data = 16'h00AA;
      step();
      chk("bp_a_vld", 32'(out_vld), 32'd1);
      chk("bp_a_data", 32'(out_data), 32'h00AA);
      chk("bp_a_rdy", 32'(in_rdy), 32'd1);
      in_data = 16'h00BB;
      step();
      chk("bp_b_data", 32'(out_data), 32'h00AA);
      chk("bp_b_rdy", 32'(in_rdy), 32'd0);
      in_data = 16'h00CC;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_data", 32'(out_data), 32'h00AA);
         chk("bp_hold_vld", 32'(out_vld), 32'd1);
         chk("bp_hold_rdy", 32'(in_rdy), 32'd0);
      end
      out_rdy = 1'b1;
      step();
      chk("bp_out_b", 32'(out_data), 32'h00BB);
      chk("bp_rdy_back", 32'(in_rdy), 32'd1);
      step();
      in_vld = 1'b0;
      chk("bp_out_c", 32'(out_data), 32'h00CC);
      chk("bp_out_c_vld", 32'(out_vld), 32'd1);
      step();
      chk("bp_empty", 32'(out_vld), 32'd0);

      // 4: random in_vld/out_rdy against the scoreboard
      prev_stall = 1'b0;
      prev_data  = '0;
      for (int c = 0; c < 3000; c++) begin
         chk("rnd_in_rdy", 32'(in_rdy), 32'(exp_q.size() < 2));
         chk("rnd_out_vld", 32'(out_vld), 32'(exp_q.size() != 0));
         if (prev_stall) begin
            chk("rnd_stable", 32'(out_data), 32'(prev_data));
         end
         in_vld  = 1'($urandom_range(0, 1));
         out_rdy = 1'($urandom_range(0, 1));
         in_data = 16'($urandom_range(0, 65535));
         do_in   = in_vld & in_rdy;
         do_out  = out_vld & out_rdy;
         if (do_out) begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
            chk("rnd_data", 32'(out_data), 32'(exp_w));
         end
         if (do_in) exp_q.push_back(in_data);
         prev_stall = out_vld & ~out_rdy;
         prev_data  = out_data;
         step();
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         if (out_vld) begin
            exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : ~out_data;
            chk("rnd_drain", 32'(out_data), 32'(exp_w));
         end
         step();
      end
      chk("rnd_q_empty", 32'(exp_q.size()), 32'd0);
      chk("rnd_end_vld", 32'(out_vld), 32'd0);

      // 5: reset while FULL
      out_rdy = 1'b0;
      in_vld  = 1'b1;
      in_data = 16'h1111;
      step();
      in_data = 16'h2222;
      step();
      chk("mid_full_rdy", 32'(in_rdy), 32'd0);
      rst     = 1'b1;
      in_data = 16'h3333;
      out_rdy = 1'b1;
      step();
      chk("mid_rst_vld", 32'(out_vld), 32'd0);
      chk("mid_rst_rdy", 32'(in_rdy), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'(RST_VAL));
      rst    = 1'b0;
      in_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid_no_stale", 32'(out_vld), 32'd0);
         chk("mid_rdy", 32'(in_rdy), 32'd1);
      end

`ifdef C3LIB_SKID_STATS_EN
      // 6: stall counter saturation and clear
      out_rdy   = 1'b0;
      in_vld    = 1'b1;
      in_data   = 16'h4444;
      stats_clr = 1'b1;
      step();
      chk("st_clr0", 32'(stall_cnt), 32'd0);
      chk("st_vld", 32'(out_vld), 32'd1);
      in_vld    = 1'b0;
      stats_clr = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("st_count", 32'(stall_cnt), 32'((k > 15) ? 15 : k));
      end
      stats_clr = 1'b1;
      step();
      chk("st_clear", 32'(stall_cnt), 32'd0);
      stats_clr = 1'b0;
      step();
      chk("st_restart", 32'(stall_cnt), 32'd1);
      out_rdy = 1'b1;
      step();
      chk("st_no_inc", 32'(stall_cnt), 32'd1);
      chk("st_out_done", 32'(out_vld), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
